fpga_cfg_loader: RTL and testbench

Upstream neighbour of the fabric top-level configuration port. Accepts a configuration bitstream as bytes over a valid/ready handshake and serialises it onto the fabric scan chain: drives ccff_head and a generated prog_clk, and monitors ccff_tail. Keeps two CRC-16 signatures, one over bits shifted in and one over bits shifted out. Loading the same bitstream twice must give a second-pass tail CRC equal to the first-pass head CRC.

---
 rtl/fpga_cfg_pkg.sv | 23 ++
 rtl/fpga_cfg_loader_crc16.sv | 30 +++
 rtl/fpga_cfg_loader.sv | 177 +++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared state encoding, CRC constants and the CRC step function
// used by the configuration-chain loader.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } cfg_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One bit of CRC-16-CCITT, MSB-first feedback, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_crc16.sv
// Bit-serial CRC-16 signature register with synchronous clear and shift enable.
module cfg_crc16
  import fpga_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_r;

  // Signature register; a clear takes priority over a shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_r <= CRC_INIT;
    end else if (clear) begin
      crc_r <= CRC_INIT;
    end else if (en) begin
      crc_r <= crc16_step(crc_r, din);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Byte-stream to fabric scan-chain serialiser: drives ccff_head with a divided
// prog_clk and keeps CRC signatures of the bits shifted in and out.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV   = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [7:0]                     cfg_data,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  output logic                           prog_clk,
  output logic                           ccff_head,
  input  logic                           ccff_tail,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count,
  output logic [15:0]                    crc_head,
  output logic [15:0]                    crc_tail
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int RW = (CW > 4) ? CW : 4;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [RW-1:0] CHAIN_RW = RW'(CHAIN_LEN);

  cfg_state_e    state_r, state_nx_s;
  logic [DW-1:0] div_cnt_r, div_nx_s;
  logic [7:0]    byte_r, byte_nx_s;
  logic [3:0]    bits_left_r, bits_left_nx_s;
  logic [CW-1:0] bit_count_r, bit_count_nx_s;
  logic          ccff_head_r, head_nx_s;
  logic          prog_clk_r, cfg_ready_r, busy_r, done_r;
  logic          crc_clr_s, crc_en_s, div_last_s;
  logic [RW-1:0] remain_s;
  logic [3:0]    first_bits_s;

  // Bit that goes onto the chain next from a byte aligned by drop_bit.
  function automatic logic lead_bit(input logic [7:0] b);
    lead_bit = (LSB_FIRST != 0) ? b[0] : b[7];
  endfunction

  function automatic logic [7:0] drop_bit(input logic [7:0] b);
    drop_bit = (LSB_FIRST != 0) ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

  assign div_last_s   = (div_cnt_r == DIV_LAST);
  assign remain_s     = CHAIN_RW - RW'(bit_count_r);
  // A short final byte uses only the bits the chain still needs.
  assign first_bits_s = (remain_s >= RW'(8)) ? 4'd8 : remain_s[3:0];

  // Next-state and datapath decode.
  always_comb begin
    state_nx_s     = state_r;
    div_nx_s       = div_cnt_r;
    byte_nx_s      = byte_r;
    bits_left_nx_s = bits_left_r;
    bit_count_nx_s = bit_count_r;
    head_nx_s      = ccff_head_r;
    crc_clr_s      = 1'b0;
    crc_en_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx_s     = ST_FETCH;
          bit_count_nx_s = {CW{1'b0}};
          crc_clr_s      = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_FETCH: begin
        if (cfg_valid && cfg_ready_r) begin
          state_nx_s     = ST_LOW;
          div_nx_s       = {DW{1'b0}};
          head_nx_s      = lead_bit(cfg_data);
          byte_nx_s      = drop_bit(cfg_data);
          bits_left_nx_s = first_bits_s;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_LOW: begin
        if (div_last_s) begin
          state_nx_s = ST_HIGH;
          div_nx_s   = {DW{1'b0}};
          crc_en_s   = 1'b1;
        end else begin
          div_nx_s = div_cnt_r + DW'(1);
        end
      end
      ST_HIGH: begin
        if (div_last_s) begin
          div_nx_s       = {DW{1'b0}};
          bit_count_nx_s = bit_count_r + CW'(1);
          bits_left_nx_s = bits_left_r - 4'd1;
          if (bit_count_r == LAST_BIT) begin
            state_nx_s = ST_DONE;
          end else if (bits_left_r != 4'd1) begin
            state_nx_s = ST_LOW;
            head_nx_s  = lead_bit(byte_r);
            byte_nx_s  = drop_bit(byte_r);
          end else begin
            state_nx_s = ST_FETCH;
          end
        end else begin
          div_nx_s = div_cnt_r + DW'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs decode the next state so
  // prog_clk is a clean flop output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      div_cnt_r   <= {DW{1'b0}};
      byte_r      <= 8'h00;
      bits_left_r <= 4'd0;
      bit_count_r <= {CW{1'b0}};
      ccff_head_r <= 1'b0;
      prog_clk_r  <= 1'b0;
      cfg_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      div_cnt_r   <= div_nx_s;
      byte_r      <= byte_nx_s;
      bits_left_r <= bits_left_nx_s;
      bit_count_r <= bit_count_nx_s;
      ccff_head_r <= head_nx_s;
      prog_clk_r  <= (state_nx_s == ST_HIGH);
      cfg_ready_r <= (state_nx_s == ST_FETCH);
      busy_r      <= (state_nx_s == ST_FETCH) || (state_nx_s == ST_LOW) ||
                     (state_nx_s == ST_HIGH);
      done_r      <= (state_nx_s == ST_DONE);
    end
  end

  // Tail is sampled just before the rising prog_clk edge shifts the chain.
  cfg_crc16 u_crc_head (
    .clk   (clk),
    .reset (reset),
    .clear (crc_clr_s),
    .en    (crc_en_s),
    .din   (ccff_head_r),
    .crc   (crc_head)
  );

  cfg_crc16 u_crc_tail (
    .clk   (clk),
    .reset (reset),
    .clear (crc_clr_s),
    .en    (crc_en_s),
    .din   (ccff_tail),
    .crc   (crc_tail)
  );

  assign prog_clk  = prog_clk_r;
  assign ccff_head = ccff_head_r;
  assign cfg_ready = cfg_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign bit_count = bit_count_r;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench: three loader instances (16/div1/LSB, 10/div1/MSB, 8/div3/LSB)
// sharing clock, reset and the byte bus.
module tb_fpga_cfg_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic [2:0]  rdy_v, pclk_v, head_v, busy_v, done_v;
  logic [4:0]  bc_a;
  logic [3:0]  bc_b, bc_c;
  logic [15:0] ch_a, ct_a, ch_b, ct_b, ch_c, ct_c;
  logic [15:0] chain_a = 16'h0000;
  logic        tail_a;
  logic        hlog_a [0:255];
  logic        hlog_b [0:255];
  int          edges_a = 0;
  int          edges_b = 0;

  int          total = 0;
  int          bad = 0;
  int          e0, n, hi_seen, highs, badrun, unstable, run;
  logic [31:0] obs;
  logic [15:0] h1;
  logic        prev_pc, prev_h;

  always #5 clk = ~clk;

  fpga_cfg_loader #(.CHAIN_LEN(16), .CLK_DIV(1), .LSB_FIRST(1)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(rdy_v[0]), .prog_clk(pclk_v[0]),
    .ccff_head(head_v[0]), .ccff_tail(tail_a), .busy(busy_v[0]),
    .done(done_v[0]), .bit_count(bc_a), .crc_head(ch_a), .crc_tail(ct_a));

  fpga_cfg_loader #(.CHAIN_LEN(10), .CLK_DIV(1), .LSB_FIRST(0)) u_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(rdy_v[1]), .prog_clk(pclk_v[1]),
    .ccff_head(head_v[1]), .ccff_tail(1'b0), .busy(busy_v[1]),
    .done(done_v[1]), .bit_count(bc_b), .crc_head(ch_b), .crc_tail(ct_b));

  fpga_cfg_loader #(.CHAIN_LEN(8), .CLK_DIV(3), .LSB_FIRST(1)) u_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(rdy_v[2]), .prog_clk(pclk_v[2]),
    .ccff_head(head_v[2]), .ccff_tail(1'b0), .busy(busy_v[2]),
    .done(done_v[2]), .bit_count(bc_c), .crc_head(ch_c), .crc_tail(ct_c));

  // 16-bit fabric chain model for instance A, plus head-bit log per edge.
  always @(posedge pclk_v[0]) begin
    chain_a <= {chain_a[14:0], head_v[0]};
    hlog_a[edges_a[7:0]] <= head_v[0];
    edges_a <= edges_a + 1;
  end
  assign tail_a = chain_a[15];

  always @(posedge pclk_v[1]) begin
    hlog_b[edges_b[7:0]] <= head_v[1];
    edges_b <= edges_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input int sel);
    int k;
    k = 0;
    @(negedge clk);
    cfg_data  = b;
    cfg_valid = 1'b1;
    while (rdy_v[sel] !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk("push_timeout", 32'(k), 32'd0);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int sel, input string tag);
    int k;
    k = 0;
    while (done_v[sel] !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(done_v[sel]), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    start_v   = 3'b000;
    cfg_data  = 8'h00;
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {17'd0, pclk_v, rdy_v, busy_v, done_v, head_v}, 32'd0);
    chk("rst_crc_a", {ch_a, ct_a}, 32'hFFFF_FFFF);
    chk("rst_bitcnt_a", 32'(bc_a), 32'd0);
    reset = 1'b0;

    // Asynchronous reset in the middle of a HIGH phase.
    pulse_start(0);
    push(8'hA5, 0);
    n = 0;
    while (pclk_v[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_high_reached", 32'(pclk_v[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_prog_clk", 32'(pclk_v[0]), 32'd0);
    chk("midrst_busy_done", {30'd0, busy_v[0], done_v[0]}, 32'd0);
    chk("midrst_crc_head", 32'(ch_a), 32'h0000_FFFF);
    e0 = edges_a;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_edges", 32'(edges_a - e0), 32'd0);

    // Basic two-byte load, no gaps.
    e0 = edges_a;
    pulse_start(0);
    chk("basic_busy", 32'(busy_v[0]), 32'd1);
    push(8'hA5, 0);
    push(8'h3C, 0);
    wait_done(0, "basic_done");
    chk("basic_edges", 32'(edges_a - e0), 32'd16);
    obs = 32'd0;
    for (int i = 0; i < 16; i++) obs[i] = hlog_a[8'(e0 + i)];
    chk("basic_seq", obs, 32'h0000_3CA5);
    chk("basic_bitcnt", 32'(bc_a), 32'd16);
    chk("basic_busy_low", 32'(busy_v[0]), 32'd0);
    chk("basic_crc_head", 32'(ch_a), 32'h0000_085B);
    h1 = ch_a;

    // Backpressure: 5 idle cycles in FETCH between bytes.
    e0 = edges_a;
    pulse_start(0);
    push(8'hA5, 0);
    n = 0;
    while (rdy_v[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    hi_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pclk_v[0] !== 1'b0) hi_seen++;
    end
    chk("gap_prog_clk_low", 32'(hi_seen), 32'd0);
    chk("gap_edges", 32'(edges_a - e0), 32'd8);
    push(8'h3C, 0);
    wait_done(0, "gap_done");
    obs = 32'd0;
    for (int i = 0; i < 16; i++) obs[i] = hlog_a[8'(e0 + i)];
    chk("gap_seq", obs, 32'h0000_3CA5);
    chk("gap_crc_head", 32'(ch_a), 32'(h1));
    chk("gap_readback_tail", 32'(ct_a), 32'(h1));

    // Readback again with a stray start pulse mid-load.
    e0 = edges_a;
    pulse_start(0);
    push(8'hA5, 0);
    pulse_start(0);
    push(8'h3C, 0);
    wait_done(0, "rb_done");
    chk("rb_edges", 32'(edges_a - e0), 32'd16);
    chk("rb_tail_vs_head", 32'(ct_a), 32'h0000_085B);
    chk("rb_bitcnt", 32'(bc_a), 32'd16);

    // Partial final byte, MSB first, chain of 10.
    e0 = edges_b;
    pulse_start(1);
    push(8'hFF, 1);
    push(8'h80, 1);
    wait_done(1, "part_done");
    chk("part_edges", 32'(edges_b - e0), 32'd10);
    obs = 32'd0;
    for (int i = 0; i < 10; i++) obs[i] = hlog_b[8'(e0 + i)];
    chk("part_seq", obs, 32'h0000_01FF);
    chk("part_bitcnt", 32'(bc_b), 32'd10);
    chk("part_head_hold", 32'(head_v[1]), 32'd0);
    @(negedge clk);
    cfg_data  = 8'h55;
    cfg_valid = 1'b1;
    hi_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy_v[1] !== 1'b0) hi_seen++;
    end
    cfg_valid = 1'b0;
    chk("part_no_third_byte", 32'(hi_seen), 32'd0);
    chk("part_edges_after", 32'(edges_b - e0), 32'd10);

    // CLK_DIV=3 phase widths and head stability across rising edges.
    pulse_start(2);
    highs = 0;
    badrun = 0;
    unstable = 0;
    fork
      push(8'h5A, 2);
      begin
        prev_pc = pclk_v[2];
        prev_h  = head_v[2];
        run = 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (pclk_v[2] === prev_pc) begin
            run++;
          end else begin
            if (prev_pc === 1'b1) begin
              highs++;
              if (run != 3) badrun++;
            end else if (highs > 0 && run != 3) begin
              badrun++;
            end
            if (pclk_v[2] === 1'b1 && head_v[2] !== prev_h) unstable++;
            run = 1;
          end
          prev_pc = pclk_v[2];
          prev_h  = head_v[2];
          if (done_v[2] === 1'b1) break;
        end
      end
    join
    chk("div3_done", 32'(done_v[2]), 32'd1);
    chk("div3_high_count", 32'(highs), 32'd8);
    chk("div3_bad_phase", 32'(badrun), 32'd0);
    chk("div3_head_unstable", 32'(unstable), 32'd0);
    chk("div3_bitcnt", 32'(bc_c), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
